// File: rtl/controle_display_pkg.sv
// Shared definitions for the display controller: FSM states and the
// reset/blank codes driven to the 7-segment converter.
package controle_display_pkg;

  typedef enum logic {
    NUMERO = 1'b0,
    LETRA  = 1'b1
  } estado_t;

  localparam logic [4:0] LETRA_APAGADA = 5'h1F;
  localparam logic [7:0] NUMERO_RESET  = 8'd0;

  // Zero-length windows/periods degenerate to a single cycle
  function automatic int unsigned minimoUm(input int unsigned valor);
    return (valor == 0) ? 1 : valor;
  endfunction

endpackage

// File: rtl/controle_display_temporizador_letra.sv
// Loadable down-counter timing the letter window; stops at zero and
// flags it so the controller knows when the window has run out.
module temporizador_letra #(
  parameter int N_TEMPO = 26
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic [N_TEMPO-1:0] valor,
  output logic               zero
);

  logic [N_TEMPO-1:0] contagem_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem_q <= '0;
    end else if (carrega) begin
      contagem_q <= valor;
    end else if (contagem_q != '0) begin
      contagem_q <= contagem_q - 1'b1;
    end
  end

  assign zero = (contagem_q == '0);

endmodule

// File: rtl/controle_display.sv
// Arbitrates the 7-segment converter between a number source and a letter
// source; letters pre-empt for a fixed window. Optional blink: PISCA_EN.
module controle_display
  import controle_display_pkg::*;
#(
  parameter int unsigned TEMPO_LETRA   = 50_000_000,
  parameter int          N_TEMPO       = 26,
  parameter int unsigned PERIODO_PISCA = 12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_numero,
  input  logic [7:0] numero_in,
  input  logic       req_letra,
  input  logic [4:0] letra_in,
  output logic       ack_numero,
  output logic       ack_letra,
  output logic       select,
  output logic [7:0] numero,
  output logic [4:0] letra,
  output logic       fim_letra
);

  localparam int unsigned TEMPO_EFETIVO = minimoUm(TEMPO_LETRA);
  localparam logic [N_TEMPO-1:0] CARGA_TIMER = N_TEMPO'(TEMPO_EFETIVO - 1);

  estado_t    estado_q;
  logic       select_q;
  logic [7:0] numero_q;
  logic [4:0] letra_q;
  logic       ackNumero_q;
  logic       ackLetra_q;
  logic       fim_q;
  logic       timerZero;

  temporizador_letra #(
    .N_TEMPO(N_TEMPO)
  ) u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .carrega(req_letra),
    .valor  (CARGA_TIMER),
    .zero   (timerZero)
  );

`ifdef PISCA_EN
  localparam int unsigned PERIODO_EFETIVO = minimoUm(PERIODO_PISCA);
  localparam int W_PISCA = (PERIODO_EFETIVO > 1) ? $clog2(PERIODO_EFETIVO) : 1;
  localparam logic [W_PISCA-1:0] FIM_FASE = W_PISCA'(PERIODO_EFETIVO - 1);

  logic [W_PISCA-1:0] fasePisca_q;
  logic               visivel_q;
  logic [4:0]         letraLatch_q;
`endif

  // A letter request wins over expiry, so timer==0 with req_letra reloads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= NUMERO;
      select_q    <= 1'b0;
      numero_q    <= NUMERO_RESET;
      letra_q     <= LETRA_APAGADA;
      ackNumero_q <= 1'b0;
      ackLetra_q  <= 1'b0;
      fim_q       <= 1'b0;
`ifdef PISCA_EN
      fasePisca_q  <= '0;
      visivel_q    <= 1'b1;
      letraLatch_q <= LETRA_APAGADA;
`endif
    end else begin
      ackNumero_q <= req_numero;
      ackLetra_q  <= req_letra;
      fim_q       <= 1'b0;
      if (req_numero) begin
        numero_q <= numero_in;
      end
      if (req_letra) begin
        estado_q <= LETRA;
        select_q <= 1'b1;
        letra_q  <= letra_in;
`ifdef PISCA_EN
        letraLatch_q <= letra_in;
        fasePisca_q  <= '0;
        visivel_q    <= 1'b1;
`endif
      end else begin
        case (estado_q)
          LETRA: begin
            if (timerZero) begin
              estado_q <= NUMERO;
              select_q <= 1'b0;
              fim_q    <= 1'b1;
`ifdef PISCA_EN
              fasePisca_q <= '0;
              visivel_q   <= 1'b1;
              letra_q     <= letraLatch_q;
`endif
            end
`ifdef PISCA_EN
            else if (fasePisca_q == FIM_FASE) begin
              fasePisca_q <= '0;
              visivel_q   <= ~visivel_q;
              letra_q     <= visivel_q ? LETRA_APAGADA : letraLatch_q;
            end else begin
              fasePisca_q <= fasePisca_q + 1'b1;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign select     = select_q;
  assign numero     = numero_q;
  assign letra      = letra_q;
  assign ack_numero = ackNumero_q;
  assign ack_letra  = ackLetra_q;
  assign fim_letra  = fim_q;

endmodule
